// File: rtl/debug_session_reader_if.sv
// Read-out beat stream of the debug session reader: four 32-bit beats per snapshot,
// valid/ready handshake, last marks the final beat.
interface debug_session_reader_if;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_last;

    modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/debug_session_reader.sv
// Debug session reader: token-checked unlock, forced key zeroization, snapshot capture and
// four-beat read-out. Optional macro DBG_AUTO_EXIT_EN ends the session after one snapshot.
module debug_session_reader #(
    parameter logic [127:0] UNLOCK_TOKEN    = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0,
    parameter int unsigned  MAX_FAILS       = 3,
    parameter int unsigned  ZEROIZE_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           dbg_req,
    input  logic [127:0]                   dbg_token,
    input  logic                           dbg_exit,
    input  logic                           zeroize_done,
    input  logic [127:0]                   debug_data,
    output logic                           key_zeroize,
    output logic                           debug_mode,
    debug_session_reader_if.master         rd,
    output logic                           unlock_fail,
    output logic                           locked_out
);
    localparam int unsigned DATA_W = 128;
    localparam int unsigned BEAT_W = 32;
    localparam int unsigned FAIL_W = 4;
    localparam int unsigned TMO_W  = 8;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [2:0] {
        IDLE, ZEROIZE, ENTER, CAPTURE, STREAM, HOLD, EXIT, LOCKOUT
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   cap_buf;
    logic [FAIL_W-1:0]   fail_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [IDX_W-1:0]    idx;

    logic [FAIL_W-1:0]   fail_inc_c;
    logic                lockout_hit_c;
    logic [IDX_W-1:0]    idx_next_c;

    // Saturating failure count and the lockout decision it feeds.
    assign fail_inc_c    = (fail_cnt == '1) ? fail_cnt : FAIL_W'(fail_cnt + 1'b1);
    assign lockout_hit_c = (fail_inc_c == FAIL_W'(MAX_FAILS));
    assign idx_next_c    = IDX_W'(idx + 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cap_buf     <= '0;
            fail_cnt    <= '0;
            tmo_cnt     <= '0;
            idx         <= '0;
            key_zeroize <= 1'b0;
            debug_mode  <= 1'b0;
            rd.rd_valid <= 1'b0;
            rd.rd_data  <= '0;
            rd.rd_last  <= 1'b0;
            unlock_fail <= 1'b0;
            locked_out  <= 1'b0;
        end else begin
            unlock_fail <= 1'b0;
            case (state)
                IDLE: begin
                    // A request right after a failure pulse is dropped so pulses never touch.
                    if (dbg_req && !unlock_fail) begin
                        if (dbg_token == UNLOCK_TOKEN) begin
                            state       <= ZEROIZE;
                            key_zeroize <= 1'b1;
                            tmo_cnt     <= '0;
                        end else begin
                            unlock_fail <= 1'b1;
                            fail_cnt    <= fail_inc_c;
                            if (lockout_hit_c) begin
                                state      <= LOCKOUT;
                                locked_out <= 1'b1;
                            end
                        end
                    end
                end
                ZEROIZE: begin
                    if (zeroize_done) begin
                        state      <= ENTER;
                        debug_mode <= 1'b1;
                    end else if (tmo_cnt == TMO_W'(ZEROIZE_TIMEOUT - 1)) begin
                        key_zeroize <= 1'b0;
                        unlock_fail <= 1'b1;
                        fail_cnt    <= fail_inc_c;
                        if (lockout_hit_c) begin
                            state      <= LOCKOUT;
                            locked_out <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        tmo_cnt <= TMO_W'(tmo_cnt + 1'b1);
                    end
                end
                ENTER: begin
                    state <= dbg_exit ? EXIT : CAPTURE;
                end
                CAPTURE: begin
                    if (dbg_exit) begin
                        state <= EXIT;
                    end else begin
                        cap_buf     <= debug_data;
                        idx         <= '0;
                        rd.rd_valid <= 1'b1;
                        rd.rd_data  <= debug_data[BEAT_W-1:0];
                        rd.rd_last  <= 1'b0;
                        state       <= STREAM;
                    end
                end
                STREAM: begin
                    if (dbg_exit) begin
                        rd.rd_valid <= 1'b0;
                        rd.rd_data  <= '0;
                        rd.rd_last  <= 1'b0;
                        state       <= EXIT;
                    end else if (rd.rd_valid && rd.rd_ready) begin
                        if (idx == IDX_W'(3)) begin
                            rd.rd_valid <= 1'b0;
                            rd.rd_data  <= '0;
                            rd.rd_last  <= 1'b0;
`ifdef DBG_AUTO_EXIT_EN
                            state       <= EXIT;
`else
                            state       <= HOLD;
`endif
                        end else begin
                            idx        <= idx_next_c;
                            rd.rd_data <= cap_buf[BEAT_W*idx_next_c +: BEAT_W];
                            rd.rd_last <= (idx_next_c == IDX_W'(3));
                        end
                    end
                end
                HOLD: begin
                    if (dbg_exit) begin
                        state <= EXIT;
                    end else if (dbg_req) begin
                        state <= ENTER;
                    end
                end
                EXIT: begin
                    // Session teardown: wipe the snapshot and forgive earlier failures.
                    cap_buf     <= '0;
                    debug_mode  <= 1'b0;
                    key_zeroize <= 1'b0;
                    fail_cnt    <= '0;
                    idx         <= '0;
                    state       <= IDLE;
                end
                LOCKOUT: begin
                    locked_out <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_debug_session_reader.sv
// Self-checking bench for debug_session_reader: directed steps with randomized data, stall and
// zeroize timing, checked against a session-level reference model.
module tb_debug_session_reader;
    localparam logic [127:0] TOKEN     = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
    localparam int unsigned  MAXF      = 3;
    localparam int unsigned  ZTIMEOUT  = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         dbg_req;
    logic [127:0] dbg_token;
    logic         dbg_exit;
    logic         zeroize_done;
    logic [127:0] debug_data;
    logic         key_zeroize;
    logic         debug_mode;
    logic         unlock_fail;
    logic         locked_out;

    debug_session_reader_if rd_if();

    debug_session_reader #(
        .UNLOCK_TOKEN   (TOKEN),
        .MAX_FAILS      (MAXF),
        .ZEROIZE_TIMEOUT(ZTIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dbg_req     (dbg_req),
        .dbg_token   (dbg_token),
        .dbg_exit    (dbg_exit),
        .zeroize_done(zeroize_done),
        .debug_data  (debug_data),
        .key_zeroize (key_zeroize),
        .debug_mode  (debug_mode),
        .rd          (rd_if.master),
        .unlock_fail (unlock_fail),
        .locked_out  (locked_out)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: session open (held), snapshot buffer contents, failure count.
    bit           model_open = 0;
    logic [127:0] model_buf = '0;
    int           model_fails = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_session_end();
        model_open  = 0;
        model_buf   = '0;
        model_fails = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_kz"}, key_zeroize, 1'b0);
        chk({tag, "_dm"}, debug_mode, 1'b0);
        chk({tag, "_valid"}, rd_if.rd_valid, 1'b0);
        chk({tag, "_data"}, rd_if.rd_data, 32'h0);
        chk({tag, "_last"}, rd_if.rd_last, 1'b0);
        chk({tag, "_fail"}, unlock_fail, 1'b0);
        chk({tag, "_lock"}, locked_out, 1'b0);
    endtask

    task automatic sync_reset();
        rst = 1'b0;
        #2;
        chk_all_zero("reset");
        step();
        rst = 1'b1;
        model_session_end();
        step();
    endtask

    // Reach ENTER: re-request from a held session, or unlock with zeroize acknowledged after zd cycles.
    task automatic start_snapshot(input logic [127:0] data, input int zd);
        debug_data = data;
        dbg_req    = 1'b1;
        if (model_open) begin
            dbg_token = {$urandom, $urandom, $urandom, $urandom};
            step();
            dbg_req = 1'b0;
        end else begin
            dbg_token = TOKEN;
            step();
            dbg_req = 1'b0;
            for (int i = 0; i < zd; i++) begin
                chk("zero_kz", key_zeroize, 1'b1);
                chk("zero_dm", debug_mode, 1'b0);
                step();
            end
            zeroize_done = 1'b1;
            step();
            zeroize_done = 1'b0;
            chk("enter_kz", key_zeroize, 1'b1);
        end
    endtask

    // stall_b1: -2 no stalls, -1 random stalls, >=0 exact stall count on beat 1. exit_at: beat to abort or -1.
    task automatic run_snapshot(input logic [127:0] data, input int stall_b1, input int exit_at);
        int stall;
        logic [31:0] word;
        chk("enter_dm", debug_mode, 1'b1);
        chk("enter_valid", rd_if.rd_valid, 1'b0);
        chk("enter_buf", dut.cap_buf, model_buf);
        step();
        chk("capture_valid", rd_if.rd_valid, 1'b0);
        step();
        for (int b = 0; b < 4; b++) begin
            word = data[32*b +: 32];
            if (stall_b1 == -2) stall = 0;
            else if (stall_b1 >= 0 && b == 1) stall = stall_b1;
            else stall = $urandom_range(0, 2);
            for (int s = 0; s < stall; s++) begin
                rd_if.rd_ready = 1'b0;
                chk("stall_valid", rd_if.rd_valid, 1'b1);
                chk("stall_data", rd_if.rd_data, word);
                chk("stall_last", rd_if.rd_last, (b == 3));
                step();
            end
            chk("beat_valid", rd_if.rd_valid, 1'b1);
            chk("beat_data", rd_if.rd_data, word);
            chk("beat_last", rd_if.rd_last, (b == 3));
            if (b == exit_at) begin
                dbg_exit = 1'b1;
                rd_if.rd_ready = 1'($urandom_range(0, 1));
                step();
                dbg_exit = 1'b0;
                rd_if.rd_ready = 1'b0;
                chk("abort_valid", rd_if.rd_valid, 1'b0);
                chk("abort_dm", debug_mode, 1'b1);
                step();
                chk("abort_dm_off", debug_mode, 1'b0);
                chk("abort_kz_off", key_zeroize, 1'b0);
                model_session_end();
                return;
            end
            rd_if.rd_ready = 1'b1;
            step();
            rd_if.rd_ready = 1'b0;
        end
        chk("done_valid", rd_if.rd_valid, 1'b0);
        chk("done_last", rd_if.rd_last, 1'b0);
        chk("done_dm", debug_mode, 1'b1);
`ifdef DBG_AUTO_EXIT_EN
        step();
        chk("auto_dm_off", debug_mode, 1'b0);
        chk("auto_kz_off", key_zeroize, 1'b0);
        model_session_end();
`else
        chk("hold_kz", key_zeroize, 1'b1);
        model_open = 1;
        model_buf  = data;
`endif
    endtask

    // Leave a held session with dbg_req raised alongside dbg_exit; exit must win.
    task automatic close_session();
        if (model_open) begin
            dbg_exit = 1'b1;
            dbg_req  = 1'b1;
            step();
            dbg_exit = 1'b0;
            dbg_req  = 1'b0;
            chk("close_dm", debug_mode, 1'b1);
            chk("close_valid", rd_if.rd_valid, 1'b0);
            step();
            chk("close_dm_off", debug_mode, 1'b0);
            chk("close_kz_off", key_zeroize, 1'b0);
            model_session_end();
        end
    endtask

    task automatic bad_token();
        dbg_req   = 1'b1;
        dbg_token = TOKEN ^ {$urandom, $urandom, $urandom, ($urandom | 32'h1)};
        step();
        dbg_req = 1'b0;
        if (model_fails < 15) model_fails++;
        chk("bad_fail", unlock_fail, 1'b1);
        chk("bad_kz", key_zeroize, 1'b0);
        chk("bad_lock", locked_out, (model_fails >= int'(MAXF)));
        step();
        chk("bad_fail_off", unlock_fail, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        rst = 1'b0;
        dbg_req = 1'b0;
        dbg_token = '0;
        dbg_exit = 1'b0;
        zeroize_done = 1'b0;
        debug_data = '0;
        rd_if.rd_ready = 1'b0;
        step();
        sync_reset();

        // Known pattern, zeroize ack 3 cycles after request, no backpressure.
        d = 128'h00000004_00000003_00000002_00000001;
        start_snapshot(d, 3);
        run_snapshot(d, -2, -1);
        // Backpressure of 5 cycles on beat 1.
        start_snapshot(d, 2);
        run_snapshot(d, 5, -1);
        close_session();

        // Abort during beat 2, then a fresh session must start from a cleared buffer.
        d = {$urandom, $urandom, $urandom, $urandom};
        start_snapshot(d, 1);
        run_snapshot(d, -1, 2);
        d = {$urandom, $urandom, $urandom, $urandom};
        start_snapshot(d, 0);
        run_snapshot(d, -1, -1);
        close_session();

        // Zeroize never acknowledged: 16 cycles of key_zeroize, then a failure pulse.
        dbg_req = 1'b1;
        dbg_token = TOKEN;
        step();
        dbg_req = 1'b0;
        for (int i = 0; i < int'(ZTIMEOUT); i++) begin
            chk("tmo_kz", key_zeroize, 1'b1);
            chk("tmo_fail", unlock_fail, 1'b0);
            chk("tmo_dm", debug_mode, 1'b0);
            step();
        end
        model_fails++;
        chk("tmo_kz_off", key_zeroize, 1'b0);
        chk("tmo_fail_pulse", unlock_fail, 1'b1);
        chk("tmo_dm_off", debug_mode, 1'b0);
        // A valid request in the failure-pulse cycle is ignored.
        dbg_req = 1'b1;
        step();
        dbg_req = 1'b0;
        chk("ignored_kz", key_zeroize, 1'b0);
        chk("ignored_fail", unlock_fail, 1'b0);
        bad_token();

        // A completed session forgives earlier failures.
        d = {$urandom, $urandom, $urandom, $urandom};
        start_snapshot(d, 4);
        run_snapshot(d, -1, -1);
        close_session();

        // Three wrong tokens lock the reader; a correct token is then ignored.
        for (int i = 0; i < int'(MAXF); i++) bad_token();
        dbg_req = 1'b1;
        dbg_token = TOKEN;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("lock_kz", key_zeroize, 1'b0);
            chk("lock_flag", locked_out, 1'b1);
            chk("lock_fail", unlock_fail, 1'b0);
        end
        dbg_req = 1'b0;
        sync_reset();

        // Asynchronous reset in the middle of the stream.
        d = {$urandom, $urandom, $urandom, $urandom};
        start_snapshot(d, 2);
        step();
        step();
        chk("pre_rst_valid", rd_if.rd_valid, 1'b1);
        chk("pre_rst_data", rd_if.rd_data, d[31:0]);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        #1;
        rst = 1'b1;
        model_session_end();
        step();

        // Randomized sessions.
        for (int n = 0; n < 8; n++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            start_snapshot(d, int'($urandom_range(0, 12)));
            run_snapshot(d, -1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
            if ($urandom_range(0, 1) == 1) close_session();
        end
        close_session();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
